three_to_eight_priority_decoder: RTL and testbench

THREE_TO_EIGHT_PRIORITY_DECODER -- requirements
Module: three_to_eight_priority_decoder

---
 rtl/prio_dec_pkg.sv | 33 +++
 rtl/one_hot_decode_3to8.sv | 15 +
 rtl/three_to_eight_priority_decoder.sv | 118 +++++++++++
 tb/tb_three_to_eight_priority_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/prio_dec_pkg.sv
// Shared types and helpers for the three-to-eight priority decoder.
// The optional ordering check is enabled by defining PRIO_DEC_ORDER_CHECK_EN.
package prio_dec_pkg;

  localparam int CODE_W     = 3;
  localparam int VEC_W      = 8;
  localparam int CNT_W      = 4;
  localparam int IDLE_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_e;

  // Everything that belongs to the frame currently being collected or emitted.
  typedef struct packed {
    logic [VEC_W-1:0]      mask;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  timeout;
    logic                  err;
  } frame_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < VEC_W; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/one_hot_decode_3to8.sv
// Combinational expansion of a 3-bit index into an 8-bit one-hot vector.
module one_hot_decode_3to8
  import prio_dec_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [VEC_W-1:0]  onehot
);

  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/three_to_eight_priority_decoder.sv
// Rebuilds an 8-bit request vector from a frame of priority-encoded codes.
// Define PRIO_DEC_ORDER_CHECK_EN to flag frames whose codes are not strictly increasing.
module three_to_eight_priority_decoder
  import prio_dec_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_vec,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_timeout,
  output logic              out_err
);

  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_LIM = IDLE_CNT_W'(IDLE_TIMEOUT);
  localparam bit                    TIMEOUT_EN  = (IDLE_TIMEOUT != 0);

  state_e           state_q, state_d;
  frame_t           frame_q, frame_d;
  logic [VEC_W-1:0] code_hot;
  logic             accept;
  logic             emitting;
  logic             order_viol;

  assign in_ready = (state_q != EMIT);
  assign accept   = in_valid && in_ready;
  assign emitting = (state_q == EMIT);

  one_hot_decode_3to8 u_one_hot (
    .code   (in_code),
    .onehot (code_hot)
  );

`ifdef PRIO_DEC_ORDER_CHECK_EN
  logic [CODE_W-1:0] prev_code_q, prev_code_d;

  // Only codes after the first of a frame are compared, so prev_code needs no frame clear.
  always_comb begin
    prev_code_d = prev_code_q;
    order_viol  = 1'b0;
    if (accept) begin
      prev_code_d = in_code;
      order_viol  = (state_q == ACCUM) && (in_code <= prev_code_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) prev_code_q <= '0;
    else     prev_code_q <= prev_code_d;
  end
`else
  assign order_viol = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d      = '0;
          frame_d.mask = code_hot;
          state_d      = in_last ? EMIT : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          frame_d.mask     = frame_q.mask | code_hot;
          frame_d.idle_cnt = '0;
          frame_d.err      = frame_q.err | order_viol;
          if (in_last) state_d = EMIT;
        end else if (TIMEOUT_EN) begin
          frame_d.idle_cnt = frame_q.idle_cnt + 1'b1;
          if (frame_d.idle_cnt == TIMEOUT_LIM) begin
            frame_d.timeout = 1'b1;
            state_d         = EMIT;
          end
        end
      end
      EMIT: begin
        // Outputs hold from frame_q until the consumer takes the vector.
        if (out_ready) begin
          frame_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        frame_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
    end
  end

  assign out_valid   = emitting;
  assign out_vec     = emitting ? frame_q.mask : '0;
  assign out_count   = emitting ? popcount(frame_q.mask) : '0;
  assign out_timeout = emitting & frame_q.timeout;
  assign out_err     = emitting & frame_q.err;

endmodule

// File: tb/tb_three_to_eight_priority_decoder.sv
// Directed self-checking bench for three_to_eight_priority_decoder (IDLE_TIMEOUT=4).
module tb_three_to_eight_priority_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_vec;
  logic [3:0] out_count;
  logic       out_timeout;
  logic       out_err;

  int total = 0;
  int bad   = 0;

`ifdef PRIO_DEC_ORDER_CHECK_EN
  localparam logic DUP_ERR = 1'b1;
`else
  localparam logic DUP_ERR = 1'b0;
`endif

  three_to_eight_priority_decoder #(.IDLE_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vec     (out_vec),
    .out_count   (out_count),
    .out_timeout (out_timeout),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] code, input logic last);
    in_valid = 1'b1;
    in_code  = code;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_vec !== 8'h00 || out_count !== 4'd0) begin bad++; $display("FAIL reset_vec: got %h/%0d want 00/0", out_vec, out_count); end
    total++; if (out_timeout !== 1'b0 || out_err !== 1'b0) begin bad++; $display("FAIL reset_flags: got %b%b want 00", out_timeout, out_err); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_last = 1'b0;
    in_code = 3'd1; tick();
    in_code = 3'd4; tick();
    in_code = 3'd6; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_latency: got %b want 1", out_valid); end
    total++; if (out_vec !== 8'h52) begin bad++; $display("FAIL b2b_vec: got %h want 52", out_vec); end
    total++; if (out_count !== 4'd3) begin bad++; $display("FAIL b2b_count: got %0d want 3", out_count); end
    total++; if (out_timeout !== 1'b0 || out_err !== 1'b0) begin bad++; $display("FAIL b2b_flags: got %b%b want 00", out_timeout, out_err); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || out_vec !== 8'h00 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_release: got v=%b vec=%h rdy=%b want 0/00/1", out_valid, out_vec, in_ready); end
  endtask

  task automatic test_duplicate();
    out_ready = 1'b1;
    send(3'd3, 1'b0);
    send(3'd3, 1'b0);
    send(3'd5, 1'b1);
    total++; if (out_valid !== 1'b1 || out_vec !== 8'h28) begin bad++; $display("FAIL dup_vec: got v=%b vec=%h want 1/28", out_valid, out_vec); end
    total++; if (out_count !== 4'd2) begin bad++; $display("FAIL dup_count: got %0d want 2", out_count); end
    total++; if (out_err !== DUP_ERR) begin bad++; $display("FAIL dup_err: got %b want %b", out_err, DUP_ERR); end
    tick();
  endtask

  task automatic test_timeout();
    out_ready = 1'b0;
    send(3'd2, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL timeout_early: idle=%0d got %b want 0", i, out_valid); end
    end
    tick();
    total++; if (out_valid !== 1'b1 || out_vec !== 8'h04) begin bad++; $display("FAIL timeout_vec: got v=%b vec=%h want 1/04", out_valid, out_vec); end
    total++; if (out_timeout !== 1'b1 || out_count !== 4'd1) begin bad++; $display("FAIL timeout_flag: got to=%b cnt=%0d want 1/1", out_timeout, out_count); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || out_timeout !== 1'b0) begin bad++; $display("FAIL timeout_release: got v=%b to=%b want 0/0", out_valid, out_timeout); end
  endtask

  task automatic test_idle_counter_clear();
    out_ready = 1'b1;
    send(3'd1, 1'b0);
    tick(); tick(); tick();
    send(3'd2, 1'b0);
    tick(); tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cnt_clear_early: got %b want 0", out_valid); end
    send(3'd3, 1'b1);
    total++; if (out_vec !== 8'h0E || out_count !== 4'd3) begin bad++; $display("FAIL cnt_clear_vec: got %h/%0d want 0e/3", out_vec, out_count); end
    total++; if (out_timeout !== 1'b0 || out_err !== 1'b0) begin bad++; $display("FAIL cnt_clear_flags: got %b%b want 00", out_timeout, out_err); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(3'd0, 1'b0);
    send(3'd7, 1'b1);
    in_valid = 1'b1; in_code = 3'd3; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || out_vec !== 8'h81 || out_count !== 4'd2 || in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold: cyc=%0d got v=%b vec=%h cnt=%0d rdy=%b want 1/81/2/0", i, out_valid, out_vec, out_count, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL stall_release: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    send(3'd5, 1'b1);
    total++; if (out_vec !== 8'h20 || out_count !== 4'd1) begin bad++; $display("FAIL stall_next: got %h/%0d want 20/1", out_vec, out_count); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    send(3'd0, 1'b0);
    send(3'd7, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_code = 3'd5; in_last = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_discard: cyc=%0d got %b want 0", i, out_valid); end
    end
    send(3'd5, 1'b1);
    total++; if (out_valid !== 1'b1 || out_vec !== 8'h20 || out_count !== 4'd1) begin bad++; $display("FAIL rst_mid_next: got v=%b %h/%0d want 1/20/1", out_valid, out_vec, out_count); end
    tick();
  endtask

  task automatic test_reset_in_emit();
    out_ready = 1'b0;
    send(3'd2, 1'b1);
    total++; if (out_valid !== 1'b1 || out_vec !== 8'h04) begin bad++; $display("FAIL rst_emit_pre: got v=%b vec=%h want 1/04", out_valid, out_vec); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || out_vec !== 8'h00 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_emit: got v=%b vec=%h rdy=%b want 0/00/1", out_valid, out_vec, in_ready); end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_duplicate();
    test_timeout();
    test_idle_counter_clear();
    test_backpressure();
    test_reset_mid_frame();
    test_reset_in_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
